// File: rtl/mem_access_pkg.sv
// Shared op codes, bus size codes, FSM encoding and helpers for the memory-access stage.
package mem_access_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] LD_B   = 8'h40;
  localparam logic [7:0] LD_H   = 8'h41;
  localparam logic [7:0] LD_W   = 8'h42;
  localparam logic [7:0] LD_BU  = 8'h43;
  localparam logic [7:0] LD_HU  = 8'h44;
  localparam logic [7:0] ST_B   = 8'h45;
  localparam logic [7:0] ST_H   = 8'h46;
  localparam logic [7:0] ST_W   = 8'h47;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int ALE_BIT = 9;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op >= LD_B) && (op <= ST_W);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == ST_B) || (op == ST_H) || (op == ST_W);
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
    logic half, word;
    half = (op == LD_H) || (op == LD_HU) || (op == ST_H);
    word = (op == LD_W) || (op == ST_W);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane formatting: load lane select/extension, store replication and strobes.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    size  = SZ_W;
    wstrb = 4'b0000;
    wdata = sdata;
    ldata = rdata;
    case (op)
      LD_B:  begin size = SZ_B; ldata = {{24{byte_sel[7]}}, byte_sel}; end
      LD_BU: begin size = SZ_B; ldata = {24'h0, byte_sel}; end
      LD_H:  begin size = SZ_H; ldata = {{16{half_sel[15]}}, half_sel}; end
      LD_HU: begin size = SZ_H; ldata = {16'h0, half_sel}; end
      ST_B:  begin size = SZ_B; wdata = {4{sdata[7:0]}};  wstrb = 4'b0001 << addr; end
      ST_H:  begin size = SZ_H; wdata = {2{sdata[15:0]}}; wstrb = 4'b0011 << addr; end
      ST_W:  begin size = SZ_W; wstrb = 4'b1111; end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: bus handshake FSM, alignment check and one-deep result register.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] inst_pc_i,
  input  logic        excp_i,
  input  logic [9:0]  excp_num_i,
  input  logic        flush_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] inst_pc_o,
  output logic        excp_o,
  output logic [9:0]  excp_num_o,
  output logic        stallreq_o
);
  state_t      state, state_nx;
  logic [7:0]  op_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [31:0] pc_q;

  logic        mem_op, mis, idle_pass, accept, mem_done;
  logic [7:0]  op_sel;
  logic [1:0]  addr_sel;
  logic [1:0]  al_size;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_ldata;

  assign mem_op    = is_mem_op(aluop_i);
  assign mis       = mem_op && is_misaligned(aluop_i, mem_addr_i[1:0]);
  assign idle_pass = (state == S_IDLE) && valid_i && (!mem_op || excp_i || mis);
  assign accept    = (state == S_IDLE) && valid_i && mem_op && !excp_i && !mis;
  assign mem_done  = !flush_i && data_data_ok_i &&
                     (((state == S_REQ) && data_addr_ok_i) || (state == S_WAIT));

  // Store formatting uses live inputs at accept; load formatting uses latched op/addr.
  assign op_sel   = (state == S_IDLE) ? aluop_i : op_q;
  assign addr_sel = (state == S_IDLE) ? mem_addr_i[1:0] : data_addr_o[1:0];

  mem_align u_align (
    .op    (op_sel),
    .addr  (addr_sel),
    .sdata (reg2_i),
    .rdata (data_rdata_i),
    .size  (al_size),
    .wstrb (al_wstrb),
    .wdata (al_wdata),
    .ldata (al_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_REQ;
      S_REQ: begin
        if (data_addr_ok_i) begin
          if (data_data_ok_i) state_nx = S_IDLE;
          else if (flush_i)   state_nx = S_DRAIN;
          else                state_nx = S_WAIT;
        end else if (flush_i) begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok_i) state_nx = S_IDLE;
        else if (flush_i)   state_nx = S_DRAIN;
      end
      S_DRAIN: if (data_data_ok_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stall drops in the completion cycle so upstream advances exactly once.
  always_comb begin
    data_req_o = 1'b0;
    stallreq_o = 1'b0;
    case (state)
      S_IDLE:  stallreq_o = accept;
      S_REQ:   begin data_req_o = 1'b1; stallreq_o = !(data_addr_ok_i && data_data_ok_i); end
      S_WAIT:  stallreq_o = !data_data_ok_i;
      S_DRAIN: stallreq_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 8'h0;
      wd_q         <= 5'h0;
      wreg_q       <= 1'b0;
      pc_q         <= 32'h0;
      data_wr_o    <= 1'b0;
      data_size_o  <= 2'h0;
      data_wstrb_o <= 4'h0;
      data_addr_o  <= 32'h0;
      data_wdata_o <= 32'h0;
    end else if (accept) begin
      op_q         <= aluop_i;
      wd_q         <= wd_i;
      wreg_q       <= wreg_i;
      pc_q         <= inst_pc_i;
      data_wr_o    <= is_store_op(aluop_i);
      data_size_o  <= al_size;
      data_wstrb_o <= al_wstrb;
      data_addr_o  <= mem_addr_i;
      data_wdata_o <= al_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o <= 1'b0;
      wd_o       <= 5'h0;
      wreg_o     <= 1'b0;
      wdata_o    <= 32'h0;
      inst_pc_o  <= 32'h0;
      excp_o     <= 1'b0;
      excp_num_o <= 10'h0;
    end else begin
      wb_valid_o <= idle_pass || mem_done;
      if (idle_pass) begin
        wd_o       <= wd_i;
        wreg_o     <= wreg_i && !excp_i && !mis;
        wdata_o    <= wdata_i;
        inst_pc_o  <= inst_pc_i;
        excp_o     <= excp_i || mis;
        excp_num_o <= excp_i ? excp_num_i : (excp_num_i | (10'd1 << ALE_BIT));
      end else if (mem_done) begin
        wd_o       <= wd_q;
        wreg_o     <= wreg_q && !is_store_op(op_q);
        wdata_o    <= is_store_op(op_q) ? 32'h0 : al_ldata;
        inst_pc_o  <= pc_q;
        excp_o     <= 1'b0;
        excp_num_o <= 10'h0;
      end
    end
  end
endmodule
